// File: rtl/mem_exc_pkg.sv
// Shared types for the M-stage address-exception unit.
// Opcodes, exception codes, access classes and FSM states.
package mem_exc_pkg;

   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;
   localparam logic [5:0] OP_SB  = 6'd40;
   localparam logic [5:0] OP_SH  = 6'd41;
   localparam logic [5:0] OP_SW  = 6'd43;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   typedef enum logic [1:0] {
      ACC_NONE,
      ACC_BYTE,
      ACC_HALF,
      ACC_WORD
   } acc_size_e;

   typedef struct packed {
      acc_size_e size;
      logic      is_load;
      logic      is_store;
   } acc_t;

   typedef enum logic {
      ST_IDLE,
      ST_PEND
   } pend_state_e;

   typedef struct packed {
      logic        valid;
      logic [5:0]  exc;
      logic [31:0] badvaddr;
   } mw_t;

   function automatic acc_t decode_acc(
      input logic [5:0] op
   );
      acc_t a;
      a = '{size: ACC_NONE,
            is_load: 1'b0,
            is_store: 1'b0};
      unique case (1'b1)
         (op == OP_LW):
            a = '{ACC_WORD, 1'b1, 1'b0};
         (op == OP_LH),
         (op == OP_LHU):
            a = '{ACC_HALF, 1'b1, 1'b0};
         (op == OP_LB),
         (op == OP_LBU):
            a = '{ACC_BYTE, 1'b1, 1'b0};
         (op == OP_SW):
            a = '{ACC_WORD, 1'b0, 1'b1};
         (op == OP_SH):
            a = '{ACC_HALF, 1'b0, 1'b1};
         (op == OP_SB):
            a = '{ACC_BYTE, 1'b0, 1'b1};
         default: ;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/mem_exc_stage_classifier.sv
// Combinational load/store address classifier.
// Flags out-of-map, misaligned and illegal device accesses.
module mem_addr_classifier
   import mem_exc_pkg::*;
#(
   parameter logic [31:0] DM_END   = 32'h0000_2FFF,
   parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
   parameter logic [31:0] DEV_END  = 32'h0000_7F1B,
   parameter int DEV_STRIDE_LOG2   = 4
) (
   input  logic [5:0]  opcode,
   input  logic [31:0] addr,
   output logic        is_load,
   output logic        is_store,
   output logic        fault
);

   localparam int WO_W = DEV_STRIDE_LOG2 - 2;
   localparam logic [WO_W-1:0] RO_WORD = WO_W'(2);

   acc_t        acc;
   logic        in_dm;
   logic        in_dev;
   logic        misalign;
   logic        dev_bad;
   logic [31:0] dev_off;
   logic        ro_word;

   assign acc      = decode_acc(opcode);
   assign is_load  = acc.is_load;
   assign is_store = acc.is_store;

   assign in_dm  = (addr <= DM_END);
   assign in_dev = (addr >= DEV_BASE)
                && (addr <= DEV_END);

   assign dev_off = addr - DEV_BASE;
   assign ro_word =
      (dev_off[DEV_STRIDE_LOG2-1:2] == RO_WORD);

   always_comb begin
      misalign = 1'b0;
      unique case (acc.size)
         ACC_WORD: misalign = |addr[1:0];
         ACC_HALF: misalign = addr[0];
         default:  misalign = 1'b0;
      endcase
   end

   // Devices accept only whole words; COUNT is never writable.
   assign dev_bad = in_dev
      && ((acc.size != ACC_WORD)
       || (acc.is_store && ro_word));

   assign fault = (acc.size != ACC_NONE)
      && (!(in_dm || in_dev)
       || misalign
       || dev_bad);

endmodule

// File: rtl/mem_exc_stage.sv
// M-stage address-exception unit and M/W register.
// Tracks one pending fault for CP0 and counts faults.
module mem_exc_stage
   import mem_exc_pkg::*;
#(
   parameter logic [31:0] DM_END   = 32'h0000_2FFF,
   parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
   parameter logic [31:0] DEV_END  = 32'h0000_7F1B,
   parameter int DEV_STRIDE_LOG2   = 4,
   parameter int CNT_W             = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m_valid,
   input  logic [5:0]       m_opcode,
   input  logic [31:0]      m_addr,
   input  logic [5:0]       m_exc_in,
   input  logic             stall,
   input  logic             flush,
   input  logic             cp0_ack,
   output logic             w_valid,
   output logic [5:0]       w_exc,
   output logic [31:0]      w_badvaddr,
   output logic             exc_pending,
   output logic [4:0]       pend_code,
   output logic [31:0]      pend_badvaddr,
   output logic [CNT_W-1:0] fault_cnt
);

   logic        is_load;
   logic        is_store;
   logic        addr_fault;
   logic        gen_fault;
   logic        load_en;
   logic        load_fault;
   mw_t         nxt;
   mw_t         w_q;
   pend_state_e state_q;
   pend_state_e state_d;
   logic        capture;
   logic        release_p;
   logic [4:0]  pcode_q;
   logic [31:0] pbad_q;
   logic [CNT_W-1:0] cnt_q;

   mem_addr_classifier #(
      .DM_END          (DM_END),
      .DEV_BASE        (DEV_BASE),
      .DEV_END         (DEV_END),
      .DEV_STRIDE_LOG2 (DEV_STRIDE_LOG2)
   ) u_cls (
      .opcode   (m_opcode),
      .addr     (m_addr),
      .is_load  (is_load),
      .is_store (is_store),
      .fault    (addr_fault)
   );

   // An earlier-stage exception masks the address check.
   assign gen_fault = m_valid
                   && !m_exc_in[5]
                   && addr_fault;

   always_comb begin
      nxt = '0;
      nxt.valid = m_valid;
      unique case (1'b1)
         !m_valid: nxt.exc = '0;
         gen_fault: begin
            nxt.exc = {1'b1,
               is_store ? EXC_ADES : EXC_ADEL};
            nxt.badvaddr = m_addr;
         end
         default: nxt.exc = m_exc_in;
      endcase
   end

   assign load_en    = !flush && !stall;
   assign load_fault = load_en && gen_fault;

   always_ff @(posedge clk) begin
      if (reset) begin
         w_q <= '0;
      end else if (flush) begin
         w_q <= '0;
      end else if (!stall) begin
         w_q <= nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      capture   = 1'b0;
      release_p = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (load_fault) begin
               state_d = ST_PEND;
               capture = 1'b1;
            end
         end
         ST_PEND: begin
            if (cp0_ack) begin
               capture   = load_fault;
               release_p = !load_fault;
               if (!load_fault) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcode_q <= '0;
         pbad_q  <= '0;
      end else if (capture) begin
         pcode_q <= nxt.exc[4:0];
         pbad_q  <= m_addr;
      end else if (release_p) begin
         pcode_q <= '0;
         pbad_q  <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load_fault
                && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign w_valid       = w_q.valid;
   assign w_exc         = w_q.exc;
   assign w_badvaddr    = w_q.badvaddr;
   assign exc_pending   = (state_q == ST_PEND);
   assign pend_code     = pcode_q;
   assign pend_badvaddr = pbad_q;
   assign fault_cnt     = cnt_q;

endmodule

// File: tb/tb_mem_exc_stage.sv
// Bench for mem_exc_stage: directed steps then random
// traffic against a memory-map reference model.
module tb_mem_exc_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_valid;
   logic [5:0]  m_opcode;
   logic [31:0] m_addr;
   logic [5:0]  m_exc_in;
   logic        stall;
   logic        flush;
   logic        cp0_ack;
   logic        w_valid;
   logic [5:0]  w_exc;
   logic [31:0] w_badvaddr;
   logic        exc_pending;
   logic [4:0]  pend_code;
   logic [31:0] pend_badvaddr;
   logic [7:0]  fault_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   int unsigned e_wv, e_wexc, e_wbad;
   int unsigned e_pend, e_pcode, e_pbad;
   int unsigned e_cnt;

   mem_exc_stage dut (
      .clk           (clk),
      .reset         (reset),
      .m_valid       (m_valid),
      .m_opcode      (m_opcode),
      .m_addr        (m_addr),
      .m_exc_in      (m_exc_in),
      .stall         (stall),
      .flush         (flush),
      .cp0_ack       (cp0_ack),
      .w_valid       (w_valid),
      .w_exc         (w_exc),
      .w_badvaddr    (w_badvaddr),
      .exc_pending   (exc_pending),
      .pend_code     (pend_code),
      .pend_badvaddr (pend_badvaddr),
      .fault_cnt     (fault_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
      end
   endtask

   // Access size in bytes (0: not a memory op).
   function automatic int op_size(input int op);
      case (op)
         35, 43:         return 4;
         33, 37, 41:     return 2;
         32, 36, 40:     return 1;
         default:        return 0;
      endcase
   endfunction

   function automatic bit op_store(input int op);
      return (op == 43) || (op == 41) || (op == 40);
   endfunction

   function automatic bit bad_addr(input int op,
                                   input int unsigned a);
      int sz;
      bit in_dm, in_dev;
      sz = op_size(op);
      if (sz == 0) return 0;
      in_dm  = (a <= 32'h2FFF);
      in_dev = (a >= 32'h7F00) && (a <= 32'h7F1B);
      if (!in_dm && !in_dev) return 1;
      if ((a % sz) != 0) return 1;
      if (in_dev && sz < 4) return 1;
      if (in_dev && op_store(op)
          && (((a - 32'h7F00) % 16) / 4 == 2))
         return 1;
      return 0;
   endfunction

   task automatic cycle(input bit v,
                        input int op,
                        input int unsigned a,
                        input int unsigned ei,
                        input bit st,
                        input bit fl,
                        input bit ak,
                        input bit rs);
      bit f, lf;
      int unsigned nexc, nbad;
      reset    = rs;
      m_valid  = v;
      m_opcode = 6'(op);
      m_addr   = a;
      m_exc_in = 6'(ei);
      stall    = st;
      flush    = fl;
      cp0_ack  = ak;
      f = 0;
      nbad = 0;
      if (!v) nexc = 0;
      else if (ei[5]) nexc = ei;
      else if (bad_addr(op, a)) begin
         f = 1;
         nexc = op_store(op) ? 32'h25 : 32'h24;
         nbad = a;
      end else nexc = ei;
      lf = f && !st && !fl && !rs;
      @(posedge clk);
      #1;
      if (rs) begin
         e_wv = 0; e_wexc = 0; e_wbad = 0;
         e_pend = 0; e_pcode = 0; e_pbad = 0;
         e_cnt = 0;
      end else begin
         if (fl) begin
            e_wv = 0; e_wexc = 0; e_wbad = 0;
         end else if (!st) begin
            e_wv = v; e_wexc = nexc; e_wbad = nbad;
         end
         if (e_pend == 0) begin
            if (lf) begin
               e_pend = 1;
               e_pcode = nexc % 32;
               e_pbad = a;
            end
         end else if (ak) begin
            if (lf) begin
               e_pcode = nexc % 32;
               e_pbad = a;
            end else e_pend = 0;
         end
         if (lf && e_cnt < 255) e_cnt++;
      end
      chk("w_valid", 32'(w_valid), e_wv);
      chk("w_exc", 32'(w_exc), e_wexc);
      chk("w_badvaddr", w_badvaddr, e_wbad);
      chk("exc_pending", 32'(exc_pending), e_pend);
      chk("fault_cnt", 32'(fault_cnt), e_cnt);
      if (e_pend != 0) begin
         chk("pend_code", 32'(pend_code), e_pcode);
         chk("pend_badvaddr", pend_badvaddr, e_pbad);
      end
   endtask

   task automatic mem(input int op,
                      input int unsigned a);
      cycle(1, op, a, 0, 0, 0, 0, 0);
   endtask

   function automatic int unsigned rnd_addr();
      case ($urandom_range(0, 5))
         0: return $urandom_range(0, 32'h2FFF);
         1: return 32'h2FF0 + $urandom_range(0, 31);
         2: return 32'h7F00 + $urandom_range(0, 31);
         3: return 32'h7EF0 + $urandom_range(0, 15);
         4: return $urandom;
         default: return $urandom_range(0, 255) * 4;
      endcase
   endfunction

   int ops [12] = '{32, 33, 35, 36, 37, 40,
                    41, 43, 0, 15, 34, 42};

   initial begin
      e_wv = 0; e_wexc = 0; e_wbad = 0;
      e_pend = 0; e_pcode = 0; e_pbad = 0;
      e_cnt = 0;
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      chk("rst_pend_code", 32'(pend_code), 0);
      chk("rst_pend_bad", pend_badvaddr, 0);

      mem(35, 32'h1004);
      chk("lw_ok_exc", 32'(w_exc), 0);

      mem(33, 32'h3);
      chk("lh_mis_exc", 32'(w_exc), 32'h24);
      chk("lh_mis_bad", w_badvaddr, 32'h3);
      chk("lh_mis_pcode", 32'(pend_code), 4);
      chk("lh_mis_cnt", 32'(fault_cnt), 1);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);

      mem(43, 32'h7F08);
      chk("sw_ro_exc", 32'(w_exc), 32'h25);
      mem(35, 32'h7F08);
      chk("lw_dev_exc", 32'(w_exc), 0);
      mem(40, 32'h7F10);
      chk("sb_dev_exc", 32'(w_exc), 32'h25);
      mem(35, 32'h3000);
      chk("lw_oom_exc", 32'(w_exc), 32'h24);
      mem(43, 32'h7F1C);
      mem(35, 32'h7F18);
      mem(43, 32'h7F04);
      cycle(1, 43, 32'h2, 32'h2A, 0, 0, 0, 0);
      chk("prior_exc", 32'(w_exc), 32'h2A);
      chk("prior_bad", w_badvaddr, 0);
      cycle(0, 35, 32'h3, 32'h2A, 0, 0, 0, 0);
      chk("inval_exc", 32'(w_exc), 0);
      cycle(1, 0, 32'h3, 32'h0B, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);

      mem(41, 32'h11);
      for (int i = 0; i < 3; i++)
         cycle(1, 40, 32'h9000_0000, 0,
               1, 0, 0, 0);
      chk("stall_bad", w_badvaddr, 32'h11);
      cycle(1, 35, 32'h5, 0, 0, 1, 0, 0);
      chk("flush_valid", 32'(w_valid), 0);
      chk("flush_exc", 32'(w_exc), 0);
      mem(35, 32'h100);
      cycle(1, 41, 32'h2F01, 0, 0, 0, 1, 0);
      chk("ack_new_pend", 32'(exc_pending), 1);
      chk("ack_new_bad", pend_badvaddr, 32'h2F01);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
      chk("ack_idle", 32'(exc_pending), 0);
      cycle(0, 0, 0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 300; i++)
         cycle(1, 32, 32'h8000_0000 + i, 0,
               0, 0, i % 2, 0);
      chk("sat_cnt", 32'(fault_cnt), 255);
      cycle(1, 35, 32'h1, 0, 0, 0, 0, 1);
      chk("rst_mid_pend", 32'(exc_pending), 0);
      chk("rst_mid_cnt", 32'(fault_cnt), 0);
      chk("rst_mid_exc", 32'(w_exc), 0);

      for (int i = 0; i < 400; i++) begin
         int unsigned ei;
         ei = ($urandom_range(0, 7) == 0)
              ? 32'h20 | $urandom_range(0, 31)
              : 0;
         cycle($urandom_range(0, 7) != 0,
               ops[$urandom_range(0, 11)],
               rnd_addr(), ei,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 2) == 0,
               $urandom_range(0, 63) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
